fft_harmonic_capture: RTL

Parametrised frame sequencer and harmonic-bin extractor. It streams N = 2^FFT_LOG2 real samples from a sample memory into the streaming FFT core and captures the complex output at NUM_HARM harmonic bins of a run-time fundamental, mapping natural bin order to the core's bit-reversed output order. It sits between the audio sample BRAM and the note-analysis logic. It supports one-shot and continuous hop-advanced framing.

---
 rtl/fft_harmonic_capture.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_harmonic_capture.sv
// Frame sequencer feeding a streaming FFT and capturing NUM_HARM harmonic bins of a run-time fundamental.
// Latency: first sample address 1 cycle after start, FFT input strobe MEM_LATENCY later, results 1 cycle after last FFT output.
// No backpressure: memory and FFT are free-running; output capture follows the FFT strobe count, so gaps are tolerated.
module fft_harmonic_capture #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FFT_LOG2     = 10,
   parameter int NUM_HARM     = 5,
   parameter int ADDR_WIDTH   = 14,
   parameter int MEM_LATENCY  = 2,
   parameter int HOP          = 512
) (
   input  logic                                    clk_in,
   input  logic                                    rst_n_in,
   input  logic                                    start_in,
   input  logic                                    continuous_in,
   input  logic [ADDR_WIDTH-1:0]                   base_addr_in,
   input  logic [FFT_LOG2-1:0]                     fund_bin_in,
   output logic [ADDR_WIDTH-1:0]                   mem_addr_out,
   input  logic signed [SAMPLE_WIDTH-1:0]          mem_data_in,
   output logic                                    fft_di_en_out,
   output logic signed [SAMPLE_WIDTH-1:0]          fft_di_re_out,
   input  logic                                    fft_do_en_in,
   input  logic signed [SAMPLE_WIDTH-1:0]          fft_do_re_in,
   input  logic signed [SAMPLE_WIDTH-1:0]          fft_do_im_in,
   output logic [NUM_HARM*2*SAMPLE_WIDTH-1:0]      coeffs_out,
   output logic [NUM_HARM-1:0]                     bin_valid_out,
   output logic                                    data_valid_out,
   output logic                                    busy_out,
   output logic [15:0]                             frame_count_out
);

   localparam int N  = 1 << FFT_LOG2;
   localparam int BW = FFT_LOG2 + 4;
   localparam logic [BW-1:0]       BIN_MAX  = BW'(N / 2 - 1);
   localparam logic [FFT_LOG2-1:0] IDX_LAST = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                                rst_sync_q, rst_sync_d;
   logic                                      rst_core_n;
   logic [1:0]                                state_q, state_d;
   logic [ADDR_WIDTH-1:0]                     base_q, base_d;
   logic [ADDR_WIDTH-1:0]                     addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]                     next_base;
   logic [FFT_LOG2-1:0]                       fetch_cnt_q, fetch_cnt_d;
   logic [FFT_LOG2-1:0]                       out_cnt_q, out_cnt_d;
   logic [MEM_LATENCY-1:0]                    en_pipe_q, en_pipe_d;
   logic [NUM_HARM-1:0][FFT_LOG2-1:0]         rev_q, rev_d;
   logic [NUM_HARM-1:0]                       hvalid_q, hvalid_d;
   logic [NUM_HARM-1:0][2*SAMPLE_WIDTH-1:0]   shadow_q, shadow_d;
   logic [NUM_HARM-1:0][2*SAMPLE_WIDTH-1:0]   coeffs_q, coeffs_d;
   logic [NUM_HARM-1:0]                       bin_valid_q, bin_valid_d;
   logic [15:0]                               frame_cnt_q, frame_cnt_d;
   logic [NUM_HARM-1:0][BW-1:0]               tgt_bin;
   logic [NUM_HARM-1:0][FFT_LOG2-1:0]         tgt_rev;
   logic [NUM_HARM-1:0]                       tgt_valid;
   logic                                      do_hit;
   logic                                      frame_end;

   // Reset is asserted asynchronously but released on a clock edge through two stages.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Reset synchroniser flops.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync_q <= '0;
      else           rst_sync_q <= rst_sync_d;
   end

   assign rst_core_n = rst_sync_q[1];
   assign next_base  = base_q + ADDR_WIDTH'(HOP);

   // Harmonic targets from the live fundamental input: k*fund, its range check, and its bit-reversed output slot.
   always_comb begin
      tgt_bin   = '0;
      tgt_rev   = '0;
      tgt_valid = '0;
      for (int k = 0; k < NUM_HARM; k++) begin
         tgt_bin[k]   = BW'(k + 1) * BW'(fund_bin_in);
         tgt_valid[k] = (tgt_bin[k] != '0) && (tgt_bin[k] <= BIN_MAX);
         for (int b = 0; b < FFT_LOG2; b++) begin
            tgt_rev[k][b] = tgt_bin[k][FFT_LOG2-1-b];
         end
      end
   end

   // Next-state logic: frame sequencing, fetch addressing, output strobe counting and bin capture.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      addr_d      = addr_q;
      fetch_cnt_d = fetch_cnt_q;
      out_cnt_d   = out_cnt_q;
      rev_d       = rev_q;
      hvalid_d    = hvalid_q;
      shadow_d    = shadow_q;
      coeffs_d    = coeffs_q;
      bin_valid_d = bin_valid_q;
      frame_cnt_d = frame_cnt_q;
      // Enable travels alongside the read so it lines up with returning data.
      en_pipe_d   = MEM_LATENCY'({en_pipe_q, (state_q == S_FETCH)});

      do_hit    = fft_do_en_in && (state_q != S_IDLE);
      frame_end = do_hit && (out_cnt_q == IDX_LAST);

      if (do_hit) begin
         out_cnt_d = out_cnt_q + FFT_LOG2'(1);
         for (int k = 0; k < NUM_HARM; k++) begin
            if (hvalid_q[k] && (out_cnt_q == rev_q[k])) begin
               shadow_d[k] = {fft_do_re_in, fft_do_im_in};
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            out_cnt_d = '0;
            if (start_in) begin
               base_d      = base_addr_in;
               addr_d      = base_addr_in;
               fetch_cnt_d = '0;
               rev_d       = tgt_rev;
               hvalid_d    = tgt_valid;
               shadow_d    = '0;
               frame_cnt_d = '0;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            fetch_cnt_d = fetch_cnt_q + FFT_LOG2'(1);
            if (fetch_cnt_q == IDX_LAST) begin
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (frame_end) begin
               coeffs_d    = shadow_d;
               bin_valid_d = hvalid_q;
               frame_cnt_d = frame_cnt_q + 16'(1);
               state_d     = S_DONE;
            end
         end
         default: begin
            if (continuous_in) begin
               base_d      = next_base;
               addr_d      = next_base;
               fetch_cnt_d = '0;
               state_d     = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_in or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         addr_q      <= '0;
         fetch_cnt_q <= '0;
         out_cnt_q   <= '0;
         en_pipe_q   <= '0;
         rev_q       <= '0;
         hvalid_q    <= '0;
         shadow_q    <= '0;
         coeffs_q    <= '0;
         bin_valid_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         fetch_cnt_q <= fetch_cnt_d;
         out_cnt_q   <= out_cnt_d;
         en_pipe_q   <= en_pipe_d;
         rev_q       <= rev_d;
         hvalid_q    <= hvalid_d;
         shadow_q    <= shadow_d;
         coeffs_q    <= coeffs_d;
         bin_valid_q <= bin_valid_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign mem_addr_out    = addr_q;
   assign fft_di_en_out   = en_pipe_q[MEM_LATENCY-1];
   assign fft_di_re_out   = mem_data_in;
   assign coeffs_out      = coeffs_q;
   assign bin_valid_out   = bin_valid_q;
   assign data_valid_out  = (state_q == S_DONE);
   assign busy_out        = (state_q != S_IDLE);
   assign frame_count_out = frame_cnt_q;

endmodule
